// File: rtl/sram_like_resp_if.sv
// sram_like_resp_if: SRAM-like request/response bus (req / addr_ok / data_ok)
// plus the test back-pressure input.
interface sram_like_resp_if;
   logic        sram_req;
   logic        sram_wr;
   logic [1:0]  sram_size;
   logic [3:0]  sram_wstrb;
   logic [31:0] sram_addr;
   logic [31:0] sram_wdata;
   logic        sram_addr_ok;
   logic        sram_data_ok;
   logic [31:0] sram_rdata;
   logic        addr_stall;

   modport master (
      output sram_req, sram_wr, sram_size, sram_wstrb, sram_addr, sram_wdata, addr_stall,
      input  sram_addr_ok, sram_data_ok, sram_rdata
   );
   modport slave (
      input  sram_req, sram_wr, sram_size, sram_wstrb, sram_addr, sram_wdata, addr_stall,
      output sram_addr_ok, sram_data_ok, sram_rdata
   );
endinterface

// File: rtl/sram_like_resp.sv
// sram_like_resp: SRAM-like slave with word memory and an in-order response
// FIFO answering each accepted request after a programmable latency.
module sram_like_resp #(
   parameter int ADDR_W  = 10,
   parameter int DEPTH   = 4,
   parameter int LATENCY = 1
) (
   input logic             clk,
   input logic             reset,
   sram_like_resp_if.slave s
);
   localparam int CW = $clog2(DEPTH + 1);
   localparam int PW = $clog2(DEPTH);

   logic [31:0]       mem_q [2**ADDR_W];
   logic [31:0]       fifo_q [DEPTH];
   logic [PW-1:0]     wp_q, rp_q;
   logic [CW-1:0]     count_q, count_d;
   logic [3:0]        tmr_q, tmr_d;
   logic [ADDR_W-1:0] idx;
   logic              push, pop, unused_ok;

   assign idx       = s.sram_addr[ADDR_W+1:2];
   assign unused_ok = ^{s.sram_size, s.sram_addr[31:ADDR_W+2], s.sram_addr[1:0]};
   // A same-cycle pop deliberately does not free a slot: acceptance sees registered count only.
   assign push = s.sram_req & ~s.addr_stall & (count_q != CW'(DEPTH)) & ~reset;
   assign pop  = (count_q != '0) & (tmr_q == '0);

   assign s.sram_addr_ok = push;
   assign s.sram_data_ok = pop;
   assign s.sram_rdata   = pop ? fifo_q[rp_q] : '0;

   always_comb begin
      count_d = count_q + CW'(push) - CW'(pop);
      tmr_d   = ((push && count_q == '0) || (pop && count_d != '0)) ? 4'(LATENCY - 1) :
                (tmr_q != '0 && count_q != '0) ? tmr_q - 4'd1 : tmr_q;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count_q <= '0;
         wp_q    <= '0;
         rp_q    <= '0;
         tmr_q   <= '0;
      end else begin
         count_q <= count_d;
         tmr_q   <= tmr_d;
         if (push) wp_q <= wp_q + PW'(1);
         if (pop) rp_q <= rp_q + PW'(1);
      end
   end

   // Memory and FIFO payload carry no reset so the array can map onto block RAM.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_q[wp_q] <= s.sram_wr ? '0 : mem_q[idx];
         for (int i = 0; i < 4; i++)
            if (s.sram_wr && s.sram_wstrb[i]) mem_q[idx][8*i +: 8] <= s.sram_wdata[8*i +: 8];
      end
   end
endmodule
